// File: rtl/sram_wb_pkg.sv
// Shared definitions for the SRAM Wishbone initiator and the slave wrapper:
// default widths and the burst-master state encoding.
package sram_wb_pkg;

   localparam int SRAM_ADDR_WD = 8;
   localparam int SRAM_DATA_WD = 32;
   localparam int SRAM_LEN_WD  = 8;
   localparam int SRAM_TIMEOUT = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WDAT = 2'd1,
      BUS  = 2'd2,
      RSP  = 2'd3
   } wb_state_e;

endpackage

// File: rtl/sram_wb_timeout.sv
// Ack watchdog: counts cycles while enabled, clears on request, and flags
// expiry once the count reaches LIMIT-1. Used under SRAM_WB_MASTER_TIMEOUT_EN.
module sram_wb_timeout #(
   parameter int LIMIT = 16
) (
   input  logic wb_clk_i,
   input  logic wb_rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int CNT_WD = $clog2(LIMIT) + 1;

   logic [CNT_WD-1:0] cnt_q;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i || clr_i) begin
         cnt_q <= '0;
      end else if (en_i && !expire_o) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign expire_o = (cnt_q == CNT_WD'(LIMIT - 1));

endmodule

// File: rtl/sram_wb_master.sv
// Command-driven Wishbone classic burst initiator: one single-beat cycle per word.
// Optional ack watchdog enabled by defining SRAM_WB_MASTER_TIMEOUT_EN.
module sram_wb_master
   import sram_wb_pkg::*;
#(
   parameter int ADDR_WD = SRAM_ADDR_WD,
   parameter int DATA_WD = SRAM_DATA_WD,
   parameter int LEN_WD  = SRAM_LEN_WD,
   parameter int TIMEOUT = SRAM_TIMEOUT
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_i,
   // Handshakes: a transfer happens on an edge where valid and ready are both
   // high; valid holds its payload until that edge, ready never depends on valid.
   input  logic                 cmd_valid_i,
   output logic                 cmd_ready_o,
   input  logic                 cmd_we_i,
   input  logic [ADDR_WD-1:0]   cmd_adr_i,
   input  logic [LEN_WD-1:0]    cmd_len_i,
   input  logic [DATA_WD/8-1:0] cmd_sel_i,
   input  logic                 wr_valid_i,
   output logic                 wr_ready_o,
   input  logic [DATA_WD-1:0]   wr_dat_i,
   output logic                 rd_valid_o,
   input  logic                 rd_ready_i,
   output logic [DATA_WD-1:0]   rd_dat_o,
   output logic                 wb_cyc_o,
   output logic                 wb_stb_o,
   output logic                 wb_we_o,
   output logic [ADDR_WD-1:0]   wb_adr_o,
   output logic [DATA_WD-1:0]   wb_dat_o,
   output logic [DATA_WD/8-1:0] wb_sel_o,
   input  logic [DATA_WD-1:0]   wb_dat_i,
   input  logic                 wb_ack_i,
   output logic                 done_o,
   output logic                 err_o,
   output wb_state_e            dbg_state_o
);

   wb_state_e            state_q, state_d;
   logic                 we_q;
   logic [LEN_WD-1:0]    cnt_q;
   logic                 last;
   logic                 adv;
   logic                 done_q, done_d;

`ifdef SRAM_WB_MASTER_TIMEOUT_EN
   logic tmo_expire;
   logic err_q, err_d;

   sram_wb_timeout #(
      .LIMIT (TIMEOUT)
   ) u_timeout (
      .wb_clk_i (wb_clk_i),
      .wb_rst_i (wb_rst_i),
      .clr_i    (state_q != BUS),
      .en_i     ((state_q == BUS) && !wb_ack_i),
      .expire_o (tmo_expire)
   );

   assign err_o = err_q;
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT != 0);
   assign err_o          = 1'b0;
`endif

   assign last = (cnt_q == '0);

   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      adv     = 1'b0;
`ifdef SRAM_WB_MASTER_TIMEOUT_EN
      err_d   = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (cmd_valid_i) state_d = cmd_we_i ? WDAT : BUS;
         end
         WDAT: begin
            if (wr_valid_i) state_d = BUS;
         end
         BUS: begin
            if (wb_ack_i) begin
               if (!we_q) begin
                  state_d = RSP;
               end else if (last) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = WDAT;
                  adv     = 1'b1;
               end
`ifdef SRAM_WB_MASTER_TIMEOUT_EN
            end else if (tmo_expire) begin
               // Ack in the limit cycle is handled above, so it wins over the abort.
               state_d = IDLE;
               err_d   = 1'b1;
`endif
            end
         end
         RSP: begin
            if (rd_ready_i) begin
               if (last) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = BUS;
                  adv     = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q  <= IDLE;
         done_q   <= 1'b0;
         we_q     <= 1'b0;
         cnt_q    <= '0;
         wb_adr_o <= '0;
         wb_sel_o <= '0;
         wb_dat_o <= '0;
         rd_dat_o <= '0;
`ifdef SRAM_WB_MASTER_TIMEOUT_EN
         err_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
`ifdef SRAM_WB_MASTER_TIMEOUT_EN
         err_q   <= err_d;
`endif
         if (state_q == IDLE && cmd_valid_i) begin
            we_q     <= cmd_we_i;
            cnt_q    <= cmd_len_i;
            wb_adr_o <= cmd_adr_i;
            wb_sel_o <= cmd_sel_i;
         end
         if (state_q == WDAT && wr_valid_i) wb_dat_o <= wr_dat_i;
         if (state_q == BUS && wb_ack_i && !we_q) rd_dat_o <= wb_dat_i;
         // Address wraps naturally at 2**ADDR_WD.
         if (adv) begin
            wb_adr_o <= wb_adr_o + 1'b1;
            cnt_q    <= cnt_q - 1'b1;
         end
      end
   end

   assign cmd_ready_o = (state_q == IDLE);
   assign wr_ready_o  = (state_q == WDAT);
   assign rd_valid_o  = (state_q == RSP);
   assign wb_cyc_o    = (state_q != IDLE);
   assign wb_stb_o    = (state_q == BUS);
   assign wb_we_o     = we_q && (state_q != IDLE);
   assign done_o      = done_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sram_wb_master.sv
// Directed bench for sram_wb_master with a one-wait Wishbone slave model and
// a queue-based scoreboard checking bus beats and read data.
module tb_sram_wb_master;
  import sram_wb_pkg::*;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int WR_W = AW + DW + SW;
`ifdef SRAM_WB_MASTER_TIMEOUT_EN
  localparam int EXP_ERR = 1;
  localparam int EXP_DONE = 6;
`else
  localparam int EXP_ERR = 0;
  localparam int EXP_DONE = 5;
`endif

  logic wb_clk_i = 1'b0;
  logic wb_rst_i = 1'b1;
  logic cmd_valid_i = 1'b0;
  logic cmd_ready_o;
  logic cmd_we_i = 1'b0;
  logic [AW-1:0] cmd_adr_i = '0;
  logic [7:0] cmd_len_i = '0;
  logic [SW-1:0] cmd_sel_i = '0;
  logic wr_valid_i = 1'b0;
  logic wr_ready_o;
  logic [DW-1:0] wr_dat_i = '0;
  logic rd_valid_o;
  logic rd_ready_i = 1'b1;
  logic [DW-1:0] rd_dat_o;
  logic wb_cyc_o, wb_stb_o, wb_we_o;
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o;
  logic [SW-1:0] wb_sel_o;
  logic [DW-1:0] wb_dat_i = '0;
  logic wb_ack_i = 1'b0;
  logic done_o, err_o;
  wb_state_e dbg_state;

  sram_wb_master #(
    .ADDR_WD(AW), .DATA_WD(DW), .LEN_WD(8), .TIMEOUT(16)
  ) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_adr_i(cmd_adr_i), .cmd_len_i(cmd_len_i), .cmd_sel_i(cmd_sel_i),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_dat_i(wr_dat_i),
    .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i), .rd_dat_o(rd_dat_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .done_o(done_o), .err_o(err_o), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 wb_clk_i = ~wb_clk_i;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  logic [WR_W-1:0] exp_wr_q[$];
  logic [DW-1:0] exp_rd_q[$];
  logic [AW-1:0] exp_ra_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  // ---------------- slave model ----------------
  logic [DW-1:0] mem [256];
  logic stb_seen = 1'b0;
  logic zero_wait = 1'b0;
  logic never_ack = 1'b0;

  initial begin
    forever begin
      tick();
      if (wb_rst_i || wb_ack_i) begin
        wb_ack_i = 1'b0;
        stb_seen = 1'b0;
      end else if (wb_cyc_o && wb_stb_o && !never_ack) begin
        if (stb_seen || zero_wait) begin
          wb_ack_i = 1'b1;
          if (wb_we_o) mem[wb_adr_o] = wb_dat_o;
          else wb_dat_i = mem[wb_adr_o];
        end else begin
          stb_seen = 1'b1;
        end
      end else begin
        stb_seen = 1'b0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic prev_ack_stb = 1'b0;

  always @(negedge wb_clk_i) begin
    if (wb_rst_i) begin
      prev_ack_stb = 1'b0;
    end else begin
      if (rd_valid_o && rd_ready_i) begin
        if (exp_rd_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL rd_unexpected: got 0x%0h with no expected entry", rd_dat_o);
        end else begin
          chk("rd_data", 64'(rd_dat_o), 64'(exp_rd_q.pop_front()));
        end
      end
      if (wb_stb_o && wb_ack_i) begin
        if (wb_we_o) begin
          if (exp_wr_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL wr_unexpected: adr 0x%0h dat 0x%0h", wb_adr_o, wb_dat_o);
          end else begin
            chk("wr_beat", 64'({wb_adr_o, wb_dat_o, wb_sel_o}), 64'(exp_wr_q.pop_front()));
          end
        end else begin
          if (exp_ra_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL rd_adr_unexpected: adr 0x%0h", wb_adr_o);
          end else begin
            chk("rd_adr", 64'(wb_adr_o), 64'(exp_ra_q.pop_front()));
          end
        end
      end
      if (prev_ack_stb) chk("stb_low_after_ack", 64'(wb_stb_o), 64'd0);
      prev_ack_stb = wb_stb_o && wb_ack_i;
      if (done_o) done_cnt++;
      if (err_o) err_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic we, input logic [AW-1:0] adr,
                          input logic [7:0] len, input logic [SW-1:0] sel);
    int n = 0;
    cmd_we_i = we; cmd_adr_i = adr; cmd_len_i = len; cmd_sel_i = sel;
    cmd_valid_i = 1'b1;
    while (!cmd_ready_o && n < 100) begin tick(); n++; end
    if (n >= 100) chk("cmd_ready_timeout", 64'(cmd_ready_o), 64'd1);
    tick();
    cmd_valid_i = 1'b0;
  endtask

  task automatic push_wr(input logic [DW-1:0] dat, input int delay);
    int n = 0;
    repeat (delay) tick();
    wr_dat_i = dat;
    wr_valid_i = 1'b1;
    while (!wr_ready_o && n < 100) begin tick(); n++; end
    if (n >= 100) chk("wr_ready_timeout", 64'(wr_ready_o), 64'd1);
    tick();
    wr_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int start);
    int n = 0;
    while (done_cnt <= start && n < 300) begin tick(); n++; end
    if (n >= 300) chk("done_timeout", 64'(done_cnt), 64'(start + 1));
  endtask

  function automatic logic [WR_W-1:0] wr_ent(input logic [AW-1:0] a,
                                             input logic [DW-1:0] d,
                                             input logic [SW-1:0] s);
    return {a, d, s};
  endfunction

  // ---------------- directed tests ----------------
  initial begin
    int d0;
    int n;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h10] = 32'hDEADBEEF;
    mem[8'h30] = 32'h11111111;
    mem[8'h31] = 32'h22222222;
    mem[8'h40] = 32'hCAFEF00D;

    // reset values
    repeat (3) tick();
    chk("rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
    chk("rst_cyc_stb", 64'({wb_cyc_o, wb_stb_o, wb_we_o}), 64'd0);
    chk("rst_streams", 64'({wr_ready_o, rd_valid_o, done_o, err_o}), 64'd0);
    chk("rst_adr", 64'(wb_adr_o), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(IDLE));
    wb_rst_i = 1'b0;
    tick();

    // T1: single-beat read at 0x10, cycle-accurate latency
    rd_ready_i = 1'b0;
    d0 = done_cnt;
    exp_ra_q.push_back(8'h10);
    exp_rd_q.push_back(32'hDEADBEEF);
    send_cmd(1'b0, 8'h10, 8'd0, 4'hF);
    chk("t1_stb_c1", 64'({wb_cyc_o, wb_stb_o, wb_we_o}), 64'b110);
    chk("t1_adr_c1", 64'(wb_adr_o), 64'h10);
    tick();
    chk("t1_rd_valid_c2", 64'(rd_valid_o), 64'd0);
    tick();
    chk("t1_rd_valid_c3", 64'(rd_valid_o), 64'd1);
    chk("t1_rd_dat_c3", 64'(rd_dat_o), 64'hDEADBEEF);
    chk("t1_stb_c3", 64'(wb_stb_o), 64'd0);
    rd_ready_i = 1'b1;
    tick();
    chk("t1_done_c4", 64'(done_o), 64'd1);
    chk("t1_cmd_ready_c4", 64'(cmd_ready_o), 64'd1);
    chk("t1_cyc_c4", 64'(wb_cyc_o), 64'd0);
    tick();

    // T2: 4-beat write from 0xFE, address wrap
    d0 = done_cnt;
    exp_wr_q.push_back(wr_ent(8'hFE, 32'd1, 4'hF));
    exp_wr_q.push_back(wr_ent(8'hFF, 32'd2, 4'hF));
    exp_wr_q.push_back(wr_ent(8'h00, 32'd3, 4'hF));
    exp_wr_q.push_back(wr_ent(8'h01, 32'd4, 4'hF));
    send_cmd(1'b1, 8'hFE, 8'd3, 4'hF);
    push_wr(32'd1, 0);
    chk("t2_stb_n1", 64'({wb_stb_o, wb_we_o}), 64'b11);
    tick();
    chk("t2_wr_ready_n2", 64'(wr_ready_o), 64'd0);
    tick();
    chk("t2_wr_ready_n3", 64'(wr_ready_o), 64'd1);
    push_wr(32'd2, 0);
    push_wr(32'd3, 0);
    push_wr(32'd4, 0);
    wait_done(d0);
    tick();
    chk("t2_done_count", 64'(done_cnt - d0), 64'd1);
    chk("t2_mem_wrap", 64'(mem[8'h00]), 64'd3);

    // T3: read backpressure, 2 beats at 0x30
    rd_ready_i = 1'b0;
    d0 = done_cnt;
    exp_ra_q.push_back(8'h30); exp_rd_q.push_back(32'h11111111);
    exp_ra_q.push_back(8'h31); exp_rd_q.push_back(32'h22222222);
    send_cmd(1'b0, 8'h30, 8'd1, 4'hF);
    n = 0;
    while (!rd_valid_o && n < 50) begin tick(); n++; end
    chk("t3_rd_valid_seen", 64'(rd_valid_o), 64'd1);
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_dat", 64'(rd_dat_o), 64'h11111111);
      chk("t3_hold_stb", 64'(wb_stb_o), 64'd0);
      tick();
    end
    rd_ready_i = 1'b1;
    wait_done(d0);
    tick();
    chk("t3_done_count", 64'(done_cnt - d0), 64'd1);

    // T4: write stall of 3 cycles at 0x20
    d0 = done_cnt;
    exp_wr_q.push_back(wr_ent(8'h20, 32'hA5A5A5A5, 4'h3));
    send_cmd(1'b1, 8'h20, 8'd0, 4'h3);
    for (int i = 0; i < 3; i++) begin
      chk("t4_stall_cyc_stb", 64'({wb_cyc_o, wb_stb_o}), 64'b10);
      tick();
    end
    push_wr(32'hA5A5A5A5, 0);
    chk("t4_stb_after_data", 64'(wb_stb_o), 64'd1);
    wait_done(d0);
    tick();

    // T5: zero-wait slave
    zero_wait = 1'b1;
    d0 = done_cnt;
    exp_ra_q.push_back(8'h40); exp_rd_q.push_back(32'hCAFEF00D);
    send_cmd(1'b0, 8'h40, 8'd0, 4'hF);
    wait_done(d0);
    zero_wait = 1'b0;
    tick();

    // T6: reset during beat 2 of a 4-beat write
    d0 = done_cnt;
    exp_wr_q.push_back(wr_ent(8'h50, 32'h5, 4'hF));
    send_cmd(1'b1, 8'h50, 8'd3, 4'hF);
    push_wr(32'h5, 0);
    push_wr(32'h6, 0);
    chk("t6_beat2_stb", 64'(wb_stb_o), 64'd1);
    wb_rst_i = 1'b1;
    tick();
    chk("t6_rst_cyc_stb", 64'({wb_cyc_o, wb_stb_o, wb_we_o}), 64'd0);
    chk("t6_rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
    chk("t6_rst_done_err", 64'({done_o, err_o}), 64'd0);
    wb_rst_i = 1'b0;
    repeat (2) tick();
    chk("t6_no_done", 64'(done_cnt - d0), 64'd0);

`ifdef SRAM_WB_MASTER_TIMEOUT_EN
    // T7: slave never acks, watchdog aborts after 16 BUS cycles
    never_ack = 1'b1;
    send_cmd(1'b0, 8'h60, 8'd0, 4'hF);
    n = 0;
    while (wb_stb_o && n < 100) begin n++; tick(); end
    chk("t7_bus_cycles", 64'(n), 64'd16);
    chk("t7_err_pulse", 64'(err_o), 64'd1);
    chk("t7_cyc_drop", 64'({wb_cyc_o, wb_stb_o}), 64'd0);
    chk("t7_cmd_ready", 64'(cmd_ready_o), 64'd1);
    never_ack = 1'b0;
    tick();
    d0 = done_cnt;
    exp_ra_q.push_back(8'h10); exp_rd_q.push_back(32'hDEADBEEF);
    send_cmd(1'b0, 8'h10, 8'd0, 4'hF);
    wait_done(d0);
    tick();
`endif

    // final consistency
    repeat (3) tick();
    chk("end_wr_q_empty", 64'(exp_wr_q.size()), 64'd0);
    chk("end_rd_q_empty", 64'(exp_rd_q.size()), 64'd0);
    chk("end_ra_q_empty", 64'(exp_ra_q.size()), 64'd0);
    chk("end_done_total", 64'(done_cnt), 64'(EXP_DONE));
    chk("end_err_total", 64'(err_cnt), 64'(EXP_ERR));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sram_wb_master.md
# sram_wb_master

Command-driven Wishbone classic initiator that drives the SRAM Wishbone slave port from on-chip logic (secure-memory controller, test sequencer). It accepts a burst command (start address, beat count, direction, byte select) and issues one single-beat Wishbone cycle per word at incrementing addresses. Write data enters and read data leaves on valid/ready streams. An optional watchdog aborts a burst whose slave never acknowledges.

## Interface
- `ADDR_WD`, 8: Wishbone/SRAM word address width.
- `DATA_WD`, 32: data width; `DATA_WD/8` byte selects.
- `LEN_WD`, 8: burst length field width; a burst is `cmd_len_i + 1` beats.
- `TIMEOUT`, 16: ack watchdog limit in cycles; used only with `SRAM_WB_MASTER_TIMEOUT_EN`.

Ports (single clock domain; reset is synchronous and active-high):
- `wb_clk_i` in 1: system clock; all logic on the rising edge.
- `wb_rst_i` in 1: synchronous, active-high reset.
- `cmd_valid_i` in 1 / `cmd_ready_o` out 1: command handshake.
- `cmd_we_i` in 1: 1 = write burst, 0 = read burst.
- `cmd_adr_i` in `ADDR_WD`: first word address.
- `cmd_len_i` in `LEN_WD`: beats minus one.
- `cmd_sel_i` in `DATA_WD/8`: byte select applied to every beat.
- `wr_valid_i` in 1 / `wr_ready_o` out 1 / `wr_dat_i` in `DATA_WD`: write data stream.
- `rd_valid_o` out 1 / `rd_ready_i` in 1 / `rd_dat_o` out `DATA_WD`: read data stream.
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o` out 1: Wishbone controls.
- `wb_adr_o` out `ADDR_WD`, `wb_dat_o` out `DATA_WD`, `wb_sel_o` out `DATA_WD/8`: Wishbone address, write data and byte select.
- `wb_dat_i` in `DATA_WD`, `wb_ack_i` in 1: slave read data and acknowledge.
- `done_o` out 1: one-cycle pulse when a burst completes normally.
- `err_o` out 1: one-cycle pulse when a burst is aborted by the watchdog.

## Operation
- FSM states: IDLE, WDAT, BUS, RSP.
- IDLE:
  - `cmd_ready_o` = 1, asserted only in IDLE.
  - On `cmd_valid_i` the block latches address, length, select and direction into registers.
  - Next state is WDAT for a write, BUS for a read.
  - `wb_cyc_o` goes high on entry to WDAT/BUS and stays high until the return to IDLE.
- WDAT:
  - `wr_ready_o` = 1.
  - On `wr_valid_i` the block registers `wr_dat_i` into `wb_dat_o` and moves to BUS.
- BUS:
  - `wb_stb_o` = 1; `wb_we_o`, `wb_adr_o`, `wb_sel_o` are stable.
  - On `wb_ack_i`, `wb_stb_o` drops on the next edge.
  - Write beat: if last, go to IDLE and pulse `done_o`; otherwise increment the address and go to WDAT.
  - Read beat: latch `wb_dat_i` into `rd_dat_o` and go to RSP.
- RSP:
  - `rd_valid_o` = 1 and `rd_dat_o` is held.
  - On `rd_ready_i`: if last, go to IDLE and pulse `done_o`; otherwise increment the address and go to BUS.
- Address arithmetic: increments modulo `2**ADDR_WD` (0xFF -> 0x00 at the default width).
- Beat counter: loaded with `cmd_len_i` and decremented per beat; the last beat is when the count is 0. Maximum burst is `2**LEN_WD` beats.
- `wb_ack_i` outside BUS is ignored.
- `wr_valid_i` outside WDAT is not accepted, because `wr_ready_o` = 0 there.

## Timing
- Reset values: all outputs 0 except `cmd_ready_o` = 1; state is IDLE.
- Reset mid-burst: on the same edge, cyc/stb drop, the burst is discarded, and neither `done_o` nor `err_o` pulses.
- `wb_stb_o` is never high for more than one cycle after `wb_ack_i` is sampled.
- Between beats of a burst, `wb_stb_o` is low for at least one cycle. This satisfies a slave that acks one cycle after stb and requires ack to be low before the next request.
- A zero-wait slave (ack in the first BUS cycle) is accepted.
- Read latency with a one-wait slave: command accepted at cycle 0, stb high at 1, ack at 2, `rd_valid_o` at 3.
- Write beat with a one-wait slave: wr accepted at n, stb at n+1, ack at n+2, `wr_ready_o` again at n+3.
- `done_o`/`err_o` pulse in the cycle the state returns to IDLE. `cmd_ready_o` is high in that same cycle.

## Configuration
- `SRAM_WB_MASTER_TIMEOUT_EN` defined:
  - A counter clears on BUS entry and increments each BUS cycle without ack.
  - When the counter reaches `TIMEOUT-1` without ack, the block drops cyc/stb, pulses `err_o`, abandons the remaining beats and returns to IDLE.
  - An ack in the same cycle as the limit wins: the beat completes normally.
- Not defined: no counter; BUS waits indefinitely and `err_o` is tied 0.

## Structure
- Package `sram_wb_pkg`: the state enum (IDLE, WDAT, BUS, RSP) and the default width constants shared with the slave wrapper.
- Sub-module `sram_wb_timeout`: clear/enable/expire counter, instantiated only under the macro.

## Test plan
- Read burst, one beat: addr 0x10, slave data 0xDEADBEEF, ack one cycle after stb -> `rd_valid_o` at cycle 3 with 0xDEADBEEF; `done_o` on `rd_ready_i`.
- Write burst, 4 beats: addr 0xFE, sel 0xF, data 1..4 -> addresses 0xFE, 0xFF, 0x00, 0x01; stb low ≥1 cycle between beats; one `done_o`.
- Read backpressure: `rd_ready_i` low for 5 cycles -> `rd_dat_o` stable; no new stb until accepted.
- Write stall: `wr_valid_i` delayed 3 cycles -> cyc stays high, stb low; the beat is issued after data arrives.
- Timeout (macro on, `TIMEOUT`=16): slave never acks -> stb/cyc drop and `err_o` pulses after 16 BUS cycles; next command is accepted.
- `wb_rst_i` asserted during beat 2 of 4 -> next edge: all outputs reset, `cmd_ready_o` = 1, no `done_o`.
